jk_flip_flop_en: RTL and testbench



---
 rtl/jk_flip_flop_en.sv | 33 +++
 tb/tb_jk_flip_flop_en.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/jk_flip_flop_en.sv
// Bank of WIDTH independent JK cells sharing clock, async active-high reset and enable.
// Latency: q updates one clock edge after j/k/enable are sampled; no backpressure, enable is a data-path hold.
module jk_flip_flop_en #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_nxt;

    // Per-bit JK characteristic: set on J, clear on K, toggle on both, hold on neither.
    always_comb begin
        q_nxt = q;
        if (enable) begin
            q_nxt = (j & ~q) | (~k & q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: tb/tb_jk_flip_flop_en.sv
// Scoreboard bench for jk_flip_flop_en: expected q pushed at drive time, popped after each rising edge.
module tb_jk_flip_flop_en;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] model_q;
    logic [W-1:0] exp_fifo[$];
    string        tag_fifo[$];

    jk_flip_flop_en #(.WIDTH(W), .RESET_VALUE('0)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .j      (j),
        .k      (k),
        .q      (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: q=%b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] jk_next(input logic [W-1:0] cur, input logic en,
                                             input logic [W-1:0] jj, input logic [W-1:0] kk);
        logic [W-1:0] nxt;
        nxt = cur;
        if (en) begin
            for (int b = 0; b < W; b++) begin
                case ({jj[b], kk[b]})
                    2'b00: nxt[b] = cur[b];
                    2'b01: nxt[b] = 1'b0;
                    2'b10: nxt[b] = 1'b1;
                    2'b11: nxt[b] = ~cur[b];
                endcase
            end
        end
        return nxt;
    endfunction

    // Drive on the falling edge, push the expectation, compare just after the next rising edge.
    task automatic cycle(input string tag, input logic en, input logic [W-1:0] jj, input logic [W-1:0] kk);
        @(negedge clk);
        enable = en;
        j      = jj;
        k      = kk;
        if (!rst) model_q = jk_next(model_q, en, jj, kk);
        exp_fifo.push_back(model_q);
        tag_fifo.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_fifo.pop_front(), q, exp_fifo.pop_front());
    endtask

    task automatic cycle1(input string tag, input logic en, input logic jb, input logic kb);
        cycle(tag, en, {W{jb}}, {W{kb}});
    endtask

    initial begin
        rst    = 1'b0;
        enable = 1'b0;
        j      = '0;
        k      = '0;
        model_q = '0;

        // Asynchronous reset with clk low: q must clear before any edge.
        #1 rst = 1'b1;
        #1 check("reset_immediate", q, '0);
        rst = 1'b0;
        #1 check("reset_release_no_edge", q, '0);

        // Enable low: nothing changes whatever j/k do.
        cycle1("en0_jk10", 1'b0, 1'b1, 1'b0);
        cycle1("en0_jk00", 1'b0, 1'b0, 1'b0);
        cycle1("en0_jk01", 1'b0, 1'b0, 1'b1);
        cycle1("en0_jk11", 1'b0, 1'b1, 1'b1);
        cycle1("en0_jk10b", 1'b0, 1'b1, 1'b0);

        // Hold, set, hold, reset.
        cycle1("hold0", 1'b1, 1'b0, 1'b0);
        cycle1("set", 1'b1, 1'b1, 1'b0);
        cycle1("hold1", 1'b1, 1'b0, 1'b0);
        cycle1("clear", 1'b1, 1'b0, 1'b1);

        // Sustained toggle: divide-by-2.
        for (int i = 0; i < 6; i++) cycle1($sformatf("toggle%0d", i), 1'b1, 1'b1, 1'b1);

        // Enable drop freezes the current value.
        for (int i = 0; i < 3; i++) cycle1($sformatf("freeze%0d", i), 1'b0, 1'b0, 1'b1);

        // Independent per-bit operation: each bit gets a different JK code.
        cycle("mixed_set", 1'b1, 4'b0101, 4'b0000);
        cycle("mixed_ops", 1'b1, 4'b1100, 4'b1010);
        cycle("mixed_ops2", 1'b1, 4'b1100, 4'b1010);

        for (int i = 0; i < 40; i++)
            cycle($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
                  W'($urandom), W'($urandom));

        // Reset mid-toggle between edges, then held across an edge with j=k=1.
        cycle1("pre_rst_set", 1'b1, 1'b1, 1'b0);
        cycle1("pre_rst_tog", 1'b1, 1'b1, 1'b1);
        cycle1("pre_rst_tog2", 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid_run", q, '0);
        model_q = '0;
        cycle1("rst_held_edge", 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        enable = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 15; i++) cycle1($sformatf("post_rst%0d", i), 1'b0, 1'b1, 1'b1);

        // Toggling resumes from the reset value.
        cycle1("resume_tog0", 1'b1, 1'b1, 1'b1);
        cycle1("resume_tog1", 1'b1, 1'b1, 1'b1);

        if (exp_fifo.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_fifo.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
